spi_pixel_loader: RTL and testbench

- SPI-slave command controller between the board SPI pins and the Rx frame buffer feeding the HDMI output.
- Oversamples SPI mode 0 in the sysclk domain, decodes a command byte, and assembles RGB888 pixels into addressed frame-buffer write requests.
- Requests go out through a 2-entry buffer with a valid/ready handshake. The block also issues a frame-swap pulse and serves a status byte on MISO.

---
 rtl/spi_pixel_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_pixel_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pixel_loader.sv
// ============================================================================
// spi_pixel_loader : SPI-slave command decoder feeding RGB888 frame-buffer writes
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_pixel_loader #(
  parameter int ADDR_W   = 16,
  parameter int FB_DEPTH = 65536
) (
  input  logic              sysclk,
  input  logic              rstn,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              CS_n,
  output logic              MISO,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [23:0]       pix_data,
  output logic              frame_swap,
  output logic              busy,
  output logic              overflow
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_ADDR_HI = 3'd2;
  localparam logic [2:0] S_ADDR_LO = 3'd3;
  localparam logic [2:0] S_PIX     = 3'd4;
  localparam logic [2:0] S_STATUS  = 3'd5;
  localparam logic [2:0] S_IGNORE  = 3'd6;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  // [1] is the synchronized level, [2] its one-cycle-old copy for edge detection
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
      cs_sync_q   <= {cs_sync_q[1:0], CS_n};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_cs_active, w_cs_fall, w_byte_done;
  logic [7:0] w_byte;

  logic [2:0]        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        pix_idx_q, pix_idx_d;
  logic [7:0]        red_q, red_d, grn_q, grn_d;
  logic              frame_swap_q, frame_swap_d;
  logic              miso_q, miso_d;
  logic [7:0]        miso_sr_q, miso_sr_d;
  logic [3:0]        miso_cnt_q, miso_cnt_d;
  logic              overflow_q, overflow_d;
  logic              push_req;

  logic [ADDR_W+23:0] mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q;
  logic               w_full, w_pop, w_push;

  assign w_sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign w_sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign w_cs_active = ~cs_sync_q[1];
  assign w_cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign w_byte      = {shift_q, mosi_sync_q[1]};
  assign w_byte_done = w_sclk_rise & w_cs_active & (bit_cnt_q == 3'd7);

  assign w_full = (count_q == 2'd2);
  assign w_pop  = (count_q != 2'd0) & pix_ready;
  assign w_push = push_req & (~w_full | w_pop);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    addr_hi_d    = addr_hi_q;
    addr_d       = addr_q;
    pix_idx_d    = pix_idx_q;
    red_d        = red_q;
    grn_d        = grn_q;
    frame_swap_d = 1'b0;
    miso_d       = miso_q;
    miso_sr_d    = miso_sr_q;
    miso_cnt_d   = miso_cnt_q;
    overflow_d   = overflow_q;
    push_req     = 1'b0;

    if (w_cs_fall) begin
      bit_cnt_d = 3'd0;
    end else if (w_sclk_rise && w_cs_active) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = w_byte[6:0];
    end

    case (state_q)
      S_IDLE: if (w_cs_fall) state_d = S_CMD;
      S_CMD: begin
        if (w_byte_done) begin
          case (w_byte)
            8'hA0: state_d = S_ADDR_HI;
            8'h5A: begin
              state_d    = S_STATUS;
              miso_sr_d  = {overflow_q, w_full, count_q, 4'b0000};
              miso_cnt_d = 4'd0;
            end
            8'hC3: begin
              frame_swap_d = 1'b1;
              state_d      = S_IGNORE;
            end
            default: state_d = S_IGNORE;
          endcase
        end
      end
      S_ADDR_HI: begin
        if (w_byte_done) begin
          addr_hi_d = w_byte;
          state_d   = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (w_byte_done) begin
          addr_d    = ADDR_W'({addr_hi_q, w_byte});
          pix_idx_d = 2'd0;
          state_d   = S_PIX;
        end
      end
      S_PIX: begin
        if (w_byte_done) begin
          case (pix_idx_q)
            2'd0: begin red_d = w_byte; pix_idx_d = 2'd1; end
            2'd1: begin grn_d = w_byte; pix_idx_d = 2'd2; end
            default: begin
              push_req  = 1'b1;
              pix_idx_d = 2'd0;
              addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
            end
          endcase
        end
      end
      S_STATUS: begin
        if (w_sclk_fall && w_cs_active) begin
          if (miso_cnt_q != 4'd8) begin
            miso_d     = miso_sr_q[7];
            miso_sr_d  = {miso_sr_q[6:0], 1'b0};
            miso_cnt_d = miso_cnt_q + 4'd1;
          end else begin
            miso_d = 1'b0;
          end
        end
      end
      default: ;
    endcase

    // Deselect aborts whatever was in flight; a fully-read status acknowledges overflow
    if (state_q != S_IDLE && cs_sync_q[1]) begin
      state_d = S_IDLE;
      miso_d  = 1'b0;
      if (state_q == S_STATUS && miso_cnt_q == 4'd8) overflow_d = 1'b0;
    end
    if (push_req && w_full && !w_pop) overflow_d = 1'b1;
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      addr_hi_q    <= 8'd0;
      addr_q       <= '0;
      pix_idx_q    <= 2'd0;
      red_q        <= 8'd0;
      grn_q        <= 8'd0;
      frame_swap_q <= 1'b0;
      miso_q       <= 1'b0;
      miso_sr_q    <= 8'd0;
      miso_cnt_q   <= 4'd0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      addr_hi_q    <= addr_hi_d;
      addr_q       <= addr_d;
      pix_idx_q    <= pix_idx_d;
      red_q        <= red_d;
      grn_q        <= grn_d;
      frame_swap_q <= frame_swap_d;
      miso_q       <= miso_d;
      miso_sr_q    <= miso_sr_d;
      miso_cnt_q   <= miso_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  // Two-entry request buffer; when full, a simultaneous pop frees the slot being written
  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= {addr_q, red_q, grn_q, w_byte};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pix_valid            = (count_q != 2'd0);
  assign {pix_addr, pix_data} = mem_q[rd_ptr_q];
  assign frame_swap           = frame_swap_q;
  assign MISO                 = miso_q;
  assign overflow             = overflow_q;
  assign busy                 = w_cs_active | pix_valid;

endmodule

`default_nettype wire

// File: tb/tb_spi_pixel_loader.sv
// ============================================================================
// tb_spi_pixel_loader : directed bench for spi_pixel_loader (full and 4-bit address builds)
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_pixel_loader;

  localparam int HALF = 80;

  logic sysclk = 1'b0;
  logic rstn = 1'b0;
  logic SCLK = 1'b0;
  logic MOSI = 1'b0;
  logic CS_n = 1'b1;
  logic pix_ready = 1'b0;
  logic ready_s = 1'b1;

  logic        MISO, pix_valid, frame_swap, busy, overflow;
  logic [15:0] pix_addr;
  logic [23:0] pix_data;
  logic        miso_s, pix_valid_s, frame_swap_s, busy_s, overflow_s;
  logic [3:0]  pix_addr_s;
  logic [23:0] pix_data_s;

  always #5 sysclk = ~sysclk;

  spi_pixel_loader #(.ADDR_W(16), .FB_DEPTH(65536)) u_dut (
    .sysclk(sysclk), .rstn(rstn), .SCLK(SCLK), .MOSI(MOSI), .CS_n(CS_n),
    .MISO(MISO), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_addr(pix_addr), .pix_data(pix_data), .frame_swap(frame_swap),
    .busy(busy), .overflow(overflow)
  );

  spi_pixel_loader #(.ADDR_W(4), .FB_DEPTH(16)) u_small (
    .sysclk(sysclk), .rstn(rstn), .SCLK(SCLK), .MOSI(MOSI), .CS_n(CS_n),
    .MISO(miso_s), .pix_valid(pix_valid_s), .pix_ready(ready_s),
    .pix_addr(pix_addr_s), .pix_data(pix_data_s), .frame_swap(frame_swap_s),
    .busy(busy_s), .overflow(overflow_s)
  );

  // Monitors only grow; the test reads them against snapshots
  logic [39:0] capm[$];
  logic [27:0] caps[$];
  int swaps = 0;
  int miso_hi = 0;

  always @(posedge sysclk) begin
    if (pix_valid && pix_ready) capm.push_back({pix_addr, pix_data});
    if (pix_valid_s && ready_s) caps.push_back({pix_addr_s, pix_data_s});
    if (frame_swap) swaps++;
    if (MISO) miso_hi++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      MOSI = tx[i];
      #HALF;
      rx[i] = MISO;
      SCLK = 1'b1;
      #HALF;
      SCLK = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] d;
    spi_byte(b, d);
  endtask

  task automatic send_pix(input logic [23:0] p);
    send(p[23:16]); send(p[15:8]); send(p[7:0]);
  endtask

  task automatic cs_lo();
    CS_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_hi();
    #HALF;
    CS_n = 1'b1;
    MOSI = 1'b0;
    #(2 * HALF);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [23:0] p0, p1;
    logic [15:0] ea0, ea1;
    logic [3:0]  sa0, sa1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bm, bs, s0, m0;
    logic [7:0] rx;

    vecs[0] = '{16'h0010, 24'hFF8001, 24'h123456, 16'h0010, 16'h0011, 4'h0, 4'h1};
    vecs[1] = '{16'hFFFF, 24'hABCDEF, 24'h010203, 16'hFFFF, 16'h0000, 4'hF, 4'h0};
    vecs[2] = '{16'h7FFF, 24'h000000, 24'hFFFFFF, 16'h7FFF, 16'h8000, 4'hF, 4'h0};
    vecs[3] = '{16'h000F, 24'h112233, 24'h445566, 16'h000F, 16'h0010, 4'hF, 4'h0};

    repeat (3) @(negedge sysclk);
    rstn = 1'b1;
    repeat (4) @(negedge sysclk);
    chk("rst_miso", MISO, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_addr", pix_addr, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_swap", frame_swap, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);

    pix_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      bm = capm.size();
      bs = caps.size();
      cs_lo();
      send(8'hA0); send(vecs[v].addr[15:8]); send(vecs[v].addr[7:0]);
      send_pix(vecs[v].p0);
      send_pix(vecs[v].p1);
      cs_hi();
      repeat (10) @(negedge sysclk);
      chk("vec_busy", busy, 0);
      chk("vec_nwr", capm.size() - bm, 2);
      chk("vec_nwr_small", caps.size() - bs, 2);
      if (capm.size() >= bm + 2) begin
        chk("vec_wr0", capm[bm], {vecs[v].ea0, vecs[v].p0});
        chk("vec_wr1", capm[bm+1], {vecs[v].ea1, vecs[v].p1});
      end
      if (caps.size() >= bs + 2) begin
        chk("vec_wr0_small", caps[bs], {vecs[v].sa0, vecs[v].p0});
        chk("vec_wr1_small", caps[bs+1], {vecs[v].sa1, vecs[v].p1});
      end
    end

    // Backpressure: two pixels held, third dropped
    pix_ready = 1'b0;
    bm = capm.size();
    cs_lo();
    send(8'hA0); send(8'h01); send(8'h00);
    send_pix(24'h102030);
    send_pix(24'h405060);
    chk("bp_hold_mid", {pix_addr, pix_data}, {16'h0100, 24'h102030});
    chk("bp_ovf_mid", overflow, 0);
    send_pix(24'h708090);
    cs_hi();
    chk("bp_valid", pix_valid, 1);
    chk("bp_hold", {pix_addr, pix_data}, {16'h0100, 24'h102030});
    chk("bp_ovf", overflow, 1);
    chk("bp_busy", busy, 1);
    chk("bp_nwr_held", capm.size() - bm, 0);
    pix_ready = 1'b1;
    repeat (6) @(negedge sysclk);
    chk("bp_nwr", capm.size() - bm, 2);
    if (capm.size() >= bm + 2) begin
      chk("bp_wr0", capm[bm], {16'h0100, 24'h102030});
      chk("bp_wr1", capm[bm+1], {16'h0101, 24'h405060});
    end
    chk("bp_drained", pix_valid, 0);

    // Status reads: first reports the overflow, second sees it acknowledged
    cs_lo();
    send(8'h5A);
    spi_byte(8'h00, rx);
    cs_hi();
    chk("stat1", rx, 8'h80);
    chk("stat1_ovf_clr", overflow, 0);
    cs_lo();
    send(8'h5A);
    spi_byte(8'h00, rx);
    cs_hi();
    chk("stat2", rx, 8'h00);

    s0 = swaps;
    cs_lo();
    send(8'hC3);
    cs_hi();
    chk("swap_once", swaps - s0, 1);

    s0 = swaps;
    m0 = miso_hi;
    bm = capm.size();
    cs_lo();
    send(8'h77); send(8'hA0); send(8'h00); send(8'h10);
    send_pix(24'h112233);
    cs_hi();
    chk("unk_nwr", capm.size() - bm, 0);
    chk("unk_swap", swaps - s0, 0);
    chk("unk_miso", miso_hi - m0, 0);

    bm = capm.size();
    cs_lo();
    send(8'hA0); send(8'h00); send(8'h20); send(8'hAA); send(8'hBB);
    cs_hi();
    chk("abort_nwr", capm.size() - bm, 0);
    chk("abort_valid", pix_valid, 0);

    // Reset in the middle of a burst with one pixel buffered
    pix_ready = 1'b0;
    cs_lo();
    send(8'hA0); send(8'h00); send(8'h30);
    send_pix(24'h112233);
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1; #HALF; SCLK = 1'b1; #HALF; SCLK = 1'b0;
    end
    chk("mid_valid", pix_valid, 1);
    #2;
    rstn = 1'b0;
    #2;
    chk("mrst_valid", pix_valid, 0);
    chk("mrst_addr", pix_addr, 0);
    chk("mrst_data", pix_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_miso", MISO, 0);
    CS_n = 1'b1;
    MOSI = 1'b0;
    repeat (3) @(negedge sysclk);
    rstn = 1'b1;
    pix_ready = 1'b1;
    repeat (4) @(negedge sysclk);
    chk("mrst_empty", pix_valid, 0);

    bm = capm.size();
    cs_lo();
    send(8'hA0); send(8'h00); send(8'h40);
    send_pix(24'h010203);
    cs_hi();
    chk("post_nwr", capm.size() - bm, 1);
    if (capm.size() >= bm + 1) chk("post_wr", capm[bm], {16'h0040, 24'h010203});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
